// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: loader FSM state encoding and word geometry shared by
// the instruction memory loader. Imported by instr_mem_ld.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

    localparam int BYTE_W = 8;

    // Byte index width; covers up to 4 bytes per word (32-bit words).
    localparam int BIDX_W = 2;

    function automatic int bytes_per_word(input int instr_wid);
        return instr_wid / BYTE_W;
    endfunction

endpackage

// File: rtl/instr_ram.sv
// instr_ram: single-port synchronous RAM, write enable, registered read
// with read enable (output holds when not reading). No reset on contents.
// Ports: clk, i_we, i_re, i_addr, i_wdata, o_rdata.
module instr_ram #(
    parameter int ADDR_WID = 10,
    parameter int DATA_WID = 16
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic                i_re,
    input  logic [ADDR_WID-1:0] i_addr,
    input  logic [DATA_WID-1:0] i_wdata,
    output logic [DATA_WID-1:0] o_rdata
);

    logic [DATA_WID-1:0] r_mem [2**ADDR_WID];
    logic [DATA_WID-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ld.sv
// instr_mem_ld: instruction memory with byte-serial program loader.
// Ports: clk, reset_n; fetch side prog_ctr/fetch_en -> instr_mem_out/
// instr_vld (1-cycle latency); load side ld_start/ld_byte/ld_byte_vld/
// ld_end -> ld_busy/ld_done/ld_ovf/ld_words.
module instr_mem_ld
    import instr_mem_pkg::*;
#(
    parameter int PROG_CTR_WID = 10,
    parameter int INSTR_WID    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PROG_CTR_WID-1:0] prog_ctr,
    input  logic                    fetch_en,
    output logic [INSTR_WID-1:0]    instr_mem_out,
    output logic                    instr_vld,
    input  logic                    ld_start,
    input  logic [7:0]              ld_byte,
    input  logic                    ld_byte_vld,
    input  logic                    ld_end,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic                    ld_ovf,
    output logic [PROG_CTR_WID:0]   ld_words
);

    localparam int BPW = bytes_per_word(INSTR_WID);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BPW - 1);
    localparam logic [PROG_CTR_WID:0] WORDS_MAX =
        {1'b1, {PROG_CTR_WID{1'b0}}};

    ld_state_t r_state;
    ld_state_t w_state_nx;

    logic [PROG_CTR_WID-1:0] r_addr;
    logic [BIDX_W-1:0]       r_idx;
    logic [INSTR_WID-1:0]    r_asm;
    logic                    r_full;
    logic                    r_ovf;
    logic [PROG_CTR_WID:0]   r_words;
    logic                    r_vld;
    logic                    r_out_ok;

    logic                    w_in_idle;
    logic                    w_in_load;
    logic                    w_acc;
    logic                    w_last;
    logic                    w_wr;
    logic                    w_fetch;
    logic [BIDX_W-1:0]       w_idx_nx;
    logic [INSTR_WID-1:0]    w_asm_nx;
    logic [PROG_CTR_WID-1:0] w_ram_addr;
    logic [INSTR_WID-1:0]    w_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: if (ld_start) w_state_nx = ST_LOAD;
            ST_LOAD: if (ld_end)   w_state_nx = ST_DONE;
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_idle = 1'b0;
        w_in_load = 1'b0;
        ld_done   = 1'b0;
        unique case (r_state)
            ST_IDLE: w_in_idle = 1'b1;
            ST_LOAD: w_in_load = 1'b1;
            ST_DONE: ld_done   = 1'b1;
            default: w_in_idle = 1'b0;
        endcase
    end

    assign ld_busy = w_in_load;

    // Bytes arriving once the last address is written are dropped.
    assign w_acc   = w_in_load & ld_byte_vld & ~r_full;
    assign w_last  = (r_idx == LAST_IDX);
    // A fetch coinciding with ld_start loses to the load.
    assign w_fetch = w_in_idle & fetch_en & ~ld_start;

    // Bytes land MSB first; unfilled low bytes stay zero for padding.
    always_comb begin
        w_asm_nx = r_asm;
        w_idx_nx = r_idx;
        if (w_acc) begin
            for (int b = 0; b < BPW; b++) begin
                if (r_idx == BIDX_W'(b))
                    w_asm_nx[(BPW-1-b)*8 +: 8] = ld_byte;
            end
            w_idx_nx = w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Write a completed word, or a partial word when the load ends.
    assign w_wr = w_in_load &
                  ((w_acc & w_last) | (ld_end & (w_idx_nx != '0)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_idx    <= '0;
            r_asm    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_words  <= '0;
            r_vld    <= 1'b0;
            r_out_ok <= 1'b0;
        end else begin
            r_vld <= w_fetch;
            if (w_fetch) r_out_ok <= 1'b1;
            if (w_in_idle && ld_start) begin
                r_addr  <= '0;
                r_idx   <= '0;
                r_asm   <= '0;
                r_full  <= 1'b0;
                r_ovf   <= 1'b0;
                r_words <= '0;
            end else if (w_in_load) begin
                if (w_wr || ld_end) begin
                    r_idx <= '0;
                    r_asm <= '0;
                end else begin
                    r_idx <= w_idx_nx;
                    r_asm <= w_asm_nx;
                end
                if (ld_byte_vld && r_full) r_ovf <= 1'b1;
                if (w_wr) begin
                    if (r_addr == '1) r_full <= 1'b1;
                    else              r_addr <= r_addr + 1'b1;
                    if (r_words != WORDS_MAX)
                        r_words <= r_words + 1'b1;
                end
            end
        end
    end

    // One port: loader owns the address while loading, fetch otherwise.
    assign w_ram_addr = w_in_load ? r_addr : prog_ctr;

    instr_ram #(
        .ADDR_WID (PROG_CTR_WID),
        .DATA_WID (INSTR_WID)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_re    (w_fetch),
        .i_addr  (w_ram_addr),
        .i_wdata (w_asm_nx),
        .o_rdata (w_rdata)
    );

    // RAM output is not reset; mask it until the first fetch after reset.
    assign instr_mem_out = r_out_ok ? w_rdata : '0;
    assign instr_vld     = r_vld;
    assign ld_ovf        = r_ovf;
    assign ld_words      = r_words;

endmodule

// File: doc/instr_mem_ld.md
INSTR_MEM_LD -- requirements
Module: instr_mem_ld

Interface
REQ-001 SHALL have parameter PROG_CTR_WID, default 10, fetch/load address width; depth = 2**PROG_CTR_WID words.
REQ-002 SHALL have parameter INSTR_WID, default 16, instruction word width; legal values are multiples of 8 from 8 to 32.
REQ-003 SHALL have ports: clk  in  1  the single clock, rising edge; reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: prog_ctr  in  PROG_CTR_WID  fetch address; fetch_en  in  1  fetch request.
REQ-005 SHALL have ports: instr_mem_out  out  INSTR_WID  fetched word; instr_vld  out  1  instr_mem_out valid.
REQ-006 SHALL have ports: ld_start  in  1  begin program load; ld_byte  in  8  load data; ld_byte_vld  in  1  ld_byte strobe; ld_end  in  1  terminate load.
REQ-007 SHALL have ports: ld_busy  out  1  load active; ld_done  out  1  one-cycle completion pulse; ld_ovf  out  1  sticky overflow flag; ld_words  out  PROG_CTR_WID+1  number of words written.

Function
REQ-008 SHALL read synchronously: instr_mem_out and instr_vld are registered, so the word at prog_ctr sampled at edge N appears after edge N, giving 1-cycle latency.
REQ-009 SHALL assert instr_vld the cycle after an edge with fetch_en=1 and state IDLE, and deassert it otherwise; instr_mem_out holds its previous value when instr_vld=0.
REQ-010 SHALL implement states IDLE, LOAD, DONE.
REQ-011 IDLE->LOAD on ld_start=1: clear load address, byte index and ld_words, clear ld_ovf, set ld_busy=1.
REQ-012 In LOAD, each ld_byte_vld=1 SHALL shift ld_byte into a word assembler, most-significant byte first; after INSTR_WID/8 bytes, the word is written to the load address on the same edge and the address increments.
REQ-013 ld_words SHALL equal the count of completed word writes and saturate at 2**PROG_CTR_WID.
REQ-014 Full: once the word at address 2**PROG_CTR_WID-1 is written, the address SHALL not wrap; further ld_byte_vld in LOAD set ld_ovf=1 and are discarded.
REQ-015 LOAD->DONE on ld_end=1; if ld_byte_vld and ld_end coincide, the byte is accepted first; a partial word is zero-padded in its low bytes and written, counting in ld_words unless full.
REQ-016 DONE SHALL pulse ld_done=1 for exactly one cycle, deassert ld_busy, and return to IDLE next cycle.
REQ-017 While ld_busy=1, fetch_en SHALL be ignored and instr_vld held 0; ld_start in LOAD or DONE SHALL be ignored.
REQ-018 ld_byte_vld, ld_end outside LOAD SHALL have no effect.
REQ-019 Memory contents SHALL be undefined out of reset and unaffected by reset; only completed loads modify them.

Reset
REQ-020 reset_n=0 SHALL immediately force state IDLE, instr_mem_out=0, instr_vld=0, ld_busy=0, ld_done=0, ld_ovf=0, ld_words=0, load address and byte index 0.
REQ-021 Reset mid-load SHALL abort the load without writing the partial word; previously written words remain.

Structure
REQ-022 State encoding and the INSTR_WID/8 bytes-per-word constant SHALL live in a shared package instr_mem_pkg.
REQ-023 Storage SHALL be one sub-module instr_ram: single-port synchronous RAM (PROG_CTR_WID, INSTR_WID), write enable, registered read, inferable as block RAM; the loader FSM and fetch logic stay in instr_mem_ld.

Verification
REQ-024 Defaults; ld_start, bytes 12 34 56 78, ld_end -> ld_words=2, ld_done one cycle; fetch addr 0 then 1 -> instr_mem_out 0x1234 then 0x5678, each 1 cycle after request.
REQ-025 Defaults; ld_start, bytes AB CD EF with ld_end coincident with EF -> ld_words=2, word1 = 0xEF00, ld_ovf=0.
REQ-026 PROG_CTR_WID=2; load 5 words (10 bytes) -> ld_words=4, ld_ovf=1, addr 0 unchanged from first word, no wrap.
REQ-027 fetch_en=1 held across ld_start -> instr_vld drops the cycle after ld_start, instr_mem_out frozen, instr_vld returns the cycle after the first fetch edge in IDLE.
REQ-028 Load 1 word 0xBEEF, start second load, send bytes 11 22 33, reset_n low mid-word -> all outputs 0 immediately; after release, fetch 0 -> 0x1122, fetch 1 -> undefined/unchanged (partial not written).
REQ-029 INSTR_WID=24; bytes 01 02 03 04 05 06 -> words 0x010203, 0x040506.
